// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one ready FU per cycle and broadcasts its result, tag and index.
// Define CDB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest requesting index wins.
module cdb_arbiter #(
    parameter int unsigned FU_NUM    = 6,
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned RB_SIZE   = 16,
    parameter int unsigned RB_INDEX  = 4,
    localparam int unsigned FuW      = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FU_NUM-1:0]             req,
    input  logic [FU_NUM*WORD_SIZE-1:0]   fu_data,
    input  logic [FU_NUM*WORD_SIZE-1:0]   fu_addr,
    input  logic [FU_NUM*RB_INDEX-1:0]    fu_rbindex,
    input  logic                          flush,
    output logic [FU_NUM-1:0]             grant,
    output logic                          cdb_valid,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [WORD_SIZE-1:0]          cdb_addr,
    output logic [RB_INDEX-1:0]           cdb_rbindex,
    output logic [FuW-1:0]                cdb_fu,
    output logic [RB_SIZE-1:0]            cdb_valid_vec
);

    logic                 cdb_valid_q;
    logic [WORD_SIZE-1:0] cdb_data_q;
    logic [WORD_SIZE-1:0] cdb_addr_q;
    logic [RB_INDEX-1:0]  cdb_rbindex_q;
    logic [FuW-1:0]       cdb_fu_q;
    logic [RB_SIZE-1:0]   cdb_valid_vec_q;
    logic [RB_SIZE-1:0]   cdb_valid_vec_d;

    logic [FuW-1:0]       start;
    logic [FuW-1:0]       win;
    logic                 found;
    logic [RB_INDEX-1:0]  win_tag;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [FuW-1:0] rr_ptr_q;
    logic [FuW-1:0] rr_ptr_d;

    assign start    = rr_ptr_q;
    assign rr_ptr_d = (32'(win) == FU_NUM - 1) ? '0 : win + 1'b1;
`else
    assign start = '0;
`endif

    // Circular search from start; a grant always implies a matching request, so grant is the transfer.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        grant = '0;
        idx   = 0;
        if (!reset && !flush) begin
            for (int unsigned k = 0; k < FU_NUM; k++) begin
                idx = 32'(start) + k;
                if (idx >= FU_NUM) begin
                    idx = idx - FU_NUM;
                end
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = FuW'(idx);
                end
            end
            if (found) begin
                grant[win] = 1'b1;
            end
        end
    end

    assign win_tag = fu_rbindex[win*RB_INDEX +: RB_INDEX];

    // Out-of-range tags decode to an all-zero vector.
    always_comb begin
        cdb_valid_vec_d = '0;
        for (int unsigned e = 0; e < RB_SIZE; e++) begin
            cdb_valid_vec_d[e] = (32'(win_tag) == e);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid_q     <= 1'b0;
            cdb_data_q      <= '0;
            cdb_addr_q      <= '0;
            cdb_rbindex_q   <= '0;
            cdb_fu_q        <= '0;
            cdb_valid_vec_q <= '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            rr_ptr_q        <= '0;
`endif
        end else if (flush) begin
            cdb_valid_q     <= 1'b0;
            cdb_valid_vec_q <= '0;
        end else if (found) begin
            cdb_valid_q     <= 1'b1;
            cdb_data_q      <= fu_data[win*WORD_SIZE +: WORD_SIZE];
            cdb_addr_q      <= fu_addr[win*WORD_SIZE +: WORD_SIZE];
            cdb_rbindex_q   <= win_tag;
            cdb_fu_q        <= win;
            cdb_valid_vec_q <= cdb_valid_vec_d;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            rr_ptr_q        <= rr_ptr_d;
`endif
        end else begin
            cdb_valid_q     <= 1'b0;
            cdb_valid_vec_q <= '0;
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_data      = cdb_data_q;
    assign cdb_addr      = cdb_addr_q;
    assign cdb_rbindex   = cdb_rbindex_q;
    assign cdb_fu        = cdb_fu_q;
    assign cdb_valid_vec = cdb_valid_vec_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow CDB_ARB_ROUND_ROBIN_EN when it is defined.
module tb_cdb_arbiter;

    localparam int unsigned FN = 6;
    localparam int unsigned WS = 32;
    localparam int unsigned RS = 16;
    localparam int unsigned RI = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [FN-1:0]     req;
    logic [FN-1:0]     grant;
    logic [FN*WS-1:0]  fu_data;
    logic [FN*WS-1:0]  fu_addr;
    logic [FN*RI-1:0]  fu_rbindex;
    logic              cdb_valid;
    logic [WS-1:0]     cdb_data;
    logic [WS-1:0]     cdb_addr;
    logic [RI-1:0]     cdb_rbindex;
    logic [2:0]        cdb_fu;
    logic [RS-1:0]     cdb_valid_vec;

    int n_vec;
    int n_err;

    cdb_arbiter #(
        .FU_NUM    (FN),
        .WORD_SIZE (WS),
        .RB_SIZE   (RS),
        .RB_INDEX  (RI)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .fu_data       (fu_data),
        .fu_addr       (fu_addr),
        .fu_rbindex    (fu_rbindex),
        .flush         (flush),
        .grant         (grant),
        .cdb_valid     (cdb_valid),
        .cdb_data      (cdb_data),
        .cdb_addr      (cdb_addr),
        .cdb_rbindex   (cdb_rbindex),
        .cdb_fu        (cdb_fu),
        .cdb_valid_vec (cdb_valid_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive request/flush then let the combinational grant settle.
    task automatic drive(input logic [FN-1:0] r, input logic f);
        req   = r;
        flush = f;
        #1;
    endtask

    task automatic set_fu(input int i, input logic [WS-1:0] d, input logic [WS-1:0] a,
                          input logic [RI-1:0] t);
        fu_data[i*WS +: WS]    = d;
        fu_addr[i*WS +: WS]    = a;
        fu_rbindex[i*RI +: RI] = t;
    endtask

    task automatic check_bcast(input string tag, input int w);
        logic [RS-1:0] v;
        v = '0;
        v[w + 8] = 1'b1;
        check_eq({tag, ".valid"}, 64'(cdb_valid), 64'd1);
        check_eq({tag, ".fu"}, 64'(cdb_fu), 64'(w));
        check_eq({tag, ".data"}, 64'(cdb_data), 64'(32'hD0 + w));
        check_eq({tag, ".addr"}, 64'(cdb_addr), 64'(32'hA0 + w));
        check_eq({tag, ".tag"}, 64'(cdb_rbindex), 64'(w + 8));
        check_eq({tag, ".vec"}, 64'(cdb_valid_vec), 64'(v));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".valid"}, 64'(cdb_valid), 64'd0);
        check_eq({tag, ".data"}, 64'(cdb_data), 64'd0);
        check_eq({tag, ".addr"}, 64'(cdb_addr), 64'd0);
        check_eq({tag, ".tag"}, 64'(cdb_rbindex), 64'd0);
        check_eq({tag, ".fu"}, 64'(cdb_fu), 64'd0);
        check_eq({tag, ".vec"}, 64'(cdb_valid_vec), 64'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        req        = '0;
        fu_data    = '0;
        fu_addr    = '0;
        fu_rbindex = '0;

        // Reset holds grant low even with requests pending.
        tick();
        drive(6'b100001, 1'b0);
        check_eq("rst_grant", 64'(grant), 64'd0);
        tick();
        check_zero("rst_out");

        // Single request from FU0, tag 3.
        reset = 1'b0;
        set_fu(0, 32'h55, 32'h100, 4'd3);
        drive(6'b000001, 1'b0);
        check_eq("fu0_grant", 64'(grant), 64'b000001);
        tick();
        check_eq("fu0_valid", 64'(cdb_valid), 64'd1);
        check_eq("fu0_data", 64'(cdb_data), 64'h55);
        check_eq("fu0_addr", 64'(cdb_addr), 64'h100);
        check_eq("fu0_vec", 64'(cdb_valid_vec), 64'h0008);

        // Idle: valid drops, payload holds.
        drive(6'b000000, 1'b0);
        check_eq("idle_grant", 64'(grant), 64'd0);
        tick();
        check_eq("idle_valid", 64'(cdb_valid), 64'd0);
        check_eq("idle_vec", 64'(cdb_valid_vec), 64'd0);
        check_eq("idle_hold", 64'(cdb_data), 64'h55);

        for (int i = 0; i < int'(FN); i++) begin
            set_fu(i, 32'hD0 + 32'(i), 32'hA0 + 32'(i), RI'(i + 8));
        end

        // Reset mid-stream so the pointer restarts at FU0.
        reset = 1'b1;
        drive(6'b000000, 1'b0);
        tick();
        reset = 1'b0;

`ifdef CDB_ARB_ROUND_ROBIN_EN
        for (int c = 0; c < 7; c++) begin
            drive(6'b111111, 1'b0);
            check_eq($sformatf("rr_all_grant%0d", c), 64'(grant), 64'(1 << (c % 6)));
            tick();
            check_bcast($sformatf("rr_all%0d", c), c % 6);
        end
        // Pointer now at 1: 101010 should rotate 1,3,5,1.
        begin
            int seq [4] = '{1, 3, 5, 1};
            for (int c = 0; c < 4; c++) begin
                drive(6'b101010, 1'b0);
                check_eq($sformatf("rr_odd_grant%0d", c), 64'(grant), 64'(1 << seq[c]));
                tick();
                check_bcast($sformatf("rr_odd%0d", c), seq[c]);
            end
        end
`else
        for (int c = 0; c < 3; c++) begin
            drive(6'b101010, 1'b0);
            check_eq($sformatf("fix_grant%0d", c), 64'(grant), 64'b000010);
            tick();
            check_bcast($sformatf("fix%0d", c), 1);
        end
        drive(6'b111111, 1'b0);
        check_eq("fix_all_grant", 64'(grant), 64'b000001);
        tick();
        check_bcast("fix_all", 0);
`endif

        // Flush suppresses grant and broadcast; payload holds.
        drive(6'b000100, 1'b1);
        check_eq("flush_grant", 64'(grant), 64'd0);
        tick();
        check_eq("flush_valid", 64'(cdb_valid), 64'd0);
        check_eq("flush_vec", 64'(cdb_valid_vec), 64'd0);
`ifdef CDB_ARB_ROUND_ROBIN_EN
        check_eq("flush_hold", 64'(cdb_data), 64'hD1);
`else
        check_eq("flush_hold", 64'(cdb_data), 64'hD0);
`endif
        drive(6'b000100, 1'b0);
        check_eq("unflush_grant", 64'(grant), 64'b000100);
        tick();
        check_bcast("unflush", 2);

        // FU2 just won; reset must restart the search at FU0, not FU3.
        reset = 1'b1;
        drive(6'b100001, 1'b0);
        check_eq("rst2_grant", 64'(grant), 64'd0);
        tick();
        check_zero("rst2_out");
        reset = 1'b0;
        drive(6'b100001, 1'b0);
        check_eq("post_rst2_grant", 64'(grant), 64'b000001);
        tick();
        check_bcast("post_rst2", 0);

        // FU5 wins (pointer wraps), then reset with a transfer pending.
        drive(6'b100000, 1'b0);
        check_eq("fu5_grant", 64'(grant), 64'b100000);
        tick();
        check_bcast("fu5", 5);
        reset = 1'b1;
        drive(6'b100001, 1'b0);
        check_eq("rst3_grant", 64'(grant), 64'd0);
        tick();
        check_zero("rst3_out");
        reset = 1'b0;
        drive(6'b100001, 1'b0);
        check_eq("post_rst3_grant", 64'(grant), 64'b000001);
        tick();
        check_bcast("post_rst3", 0);

        // Back-to-back single requester with extreme tags.
        set_fu(3, 32'hD3, 32'hA3, 4'd15);
        drive(6'b001000, 1'b0);
        check_eq("tag15_grant", 64'(grant), 64'b001000);
        tick();
        check_eq("tag15_vec", 64'(cdb_valid_vec), 64'h8000);
        check_eq("tag15_tag", 64'(cdb_rbindex), 64'd15);
        set_fu(3, 32'hD3, 32'hA3, 4'd0);
        drive(6'b001000, 1'b0);
        check_eq("tag0_grant", 64'(grant), 64'b001000);
        tick();
        check_eq("tag0_valid", 64'(cdb_valid), 64'd1);
        check_eq("tag0_vec", 64'(cdb_valid_vec), 64'h0001);
        drive(6'b000000, 1'b0);
        tick();
        check_eq("tag_idle_valid", 64'(cdb_valid), 64'd0);
        check_eq("tag_idle_vec", 64'(cdb_valid_vec), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter FU_NUM, default 6, number of functional units competing for the CDB.
REQ-002 Parameter WORD_SIZE, default 32, data/address width.
REQ-003 Parameter RB_SIZE, default 16, reorder-buffer entries; RB_INDEX, default 4, tag width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  FU_NUM  per-FU result-ready request.
REQ-007 fu_data  input  FU_NUM*WORD_SIZE  packed results; FU i in bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 fu_addr  input  FU_NUM*WORD_SIZE  packed store/branch addresses, same packing.
REQ-009 fu_rbindex  input  FU_NUM*RB_INDEX  packed ROB tags, same packing.
REQ-010 flush  input  1  branch-mispredict squash from ROB.
REQ-011 grant  output  FU_NUM  combinational one-hot grant.
REQ-012 cdb_valid  output  1  registered broadcast valid.
REQ-013 cdb_data, cdb_addr  output  WORD_SIZE each  registered broadcast payload.
REQ-014 cdb_rbindex  output  RB_INDEX  registered tag of broadcast.
REQ-015 cdb_fu  output  FU_NUM-width index field (clog2(FU_NUM))  registered winning FU.
REQ-016 cdb_valid_vec  output  RB_SIZE  one-hot ROB-entry valid; bit cdb_rbindex set iff cdb_valid.

Function
REQ-017 grant SHALL be zero when flush=1, reset=1, or req=0; otherwise exactly one bit set, selecting a requesting FU.
REQ-018 Selection SHALL search from rr_ptr upward with wrap at FU_NUM; first requesting FU wins.
REQ-019 Transfer SHALL occur at a posedge where req[i] and grant[i] are both high; FU i treats grant as its consume strobe.
REQ-020 FU SHALL hold req and payload stable until granted; arbiter never drops a granted transfer.
REQ-021 On transfer of winner w: cdb_valid<=1, cdb_data/addr/rbindex<=FU w fields, cdb_fu<=w, rr_ptr<=(w+1) mod FU_NUM.
REQ-022 Latency: one cycle from granted posedge to cdb_valid high; throughput one broadcast per cycle.
REQ-023 Cycle with no transfer: cdb_valid<=0; payload registers hold previous values; rr_ptr unchanged.
REQ-024 flush=1 at posedge: cdb_valid<=0 and cdb_valid_vec<=0 regardless of req; rr_ptr unchanged.
REQ-025 rr_ptr wrap: w=FU_NUM-1 SHALL set rr_ptr to 0.
REQ-026 Single requester SHALL be granted every cycle it requests (no idle bubbles).
REQ-027 cdb_valid_vec SHALL be a registered decode of tag, updated in the same edge as cdb_valid.
REQ-028 Tag values >= RB_SIZE SHALL produce cdb_valid_vec=0 while cdb_valid=1.

Reset
REQ-029 reset=1 at posedge: cdb_valid=0, cdb_valid_vec=0, cdb_data=0, cdb_addr=0, cdb_rbindex=0, cdb_fu=0, rr_ptr=0.
REQ-030 reset SHALL override flush and any pending transfer; grant=0 while reset high.
REQ-031 Reset mid-operation SHALL discard the in-flight broadcast; first grant after reset starts search at FU 0.

Configuration
REQ-032 Macro CDB_ARB_ROUND_ROBIN_EN defined: rotating priority per REQ-018/021/025.
REQ-033 Macro undefined: fixed priority, lowest requesting index wins, rr_ptr logic absent (search always starts at 0); all other requirements unchanged.

Verification
REQ-034 req=6'b000001, fu_rbindex[0]=3, fu_data[0]=0x55 -> grant=000001; next cycle cdb_valid=1, cdb_data=0x55, cdb_valid_vec=16'h0008.
REQ-035 RR_EN, req=6'b111111 held 7 cycles -> grants FU0,1,2,3,4,5,0 in order; cdb_fu sequence matches.
REQ-036 RR_EN off, req=6'b101010 held 3 cycles -> grant=000010 each cycle; FU5 starves.
REQ-037 req=6'b000100 with flush=1 -> grant=0, cdb_valid=0 next cycle; flush deasserted -> FU2 granted following cycle.
REQ-038 RR_EN, grant FU5, then reset for one cycle with req=6'b100001 -> outputs zero; first post-reset grant = FU0.
REQ-039 fu_rbindex=15 then 0 on consecutive transfers -> cdb_valid_vec=16'h8000 then 16'h0001; idle cycle -> 0.
